// File: rtl/phase_sequencer.sv
// phase_sequencer: run/stop and phase sequencer for the 16-bit multi-cycle
// processor. Walks the datapath through phases 1..NUM_PHASES once per
// instruction, handles start/stop, single-step and HLT requests, and holds
// the fetch and load/store phases while memory reports busy.
module phase_sequencer #(
    parameter int unsigned NUM_PHASES = 5,   // legal range 2..7
    parameter int unsigned STALL_PH_A = 1,   // fetch phase, holds on mem_busy
    parameter int unsigned STALL_PH_B = 4,   // load/store phase, holds on mem_busy
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic             step,
    input  logic             halt_req,
    input  logic             mem_busy,
    output logic [2:0]       phase,
    output logic             executing,
    output logic             ir_e,
    output logic             pc_e,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_STEP = 2'd2
    } mode_e;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FIRST = 3'd1;
    localparam logic [2:0] PH_LAST  = 3'(NUM_PHASES);
    localparam logic [2:0] PH_A     = 3'(STALL_PH_A);
    localparam logic [2:0] PH_B     = 3'(STALL_PH_B);

    mode_e            mode_q,      mode_d;
    logic [2:0]       phase_q,     phase_d;
    logic             stop_pend_q, stop_pend_d;
    logic             halted_q,    halted_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             exec_q;
    logic             pc_e_q;

    logic             in_stall_phase;
    logic             stall;
    logic             stop_now;

    // Stall qualification: only the two memory phases hold, and the final
    // phase is excluded so pc_e stays a single-cycle pulse.
    always_comb begin
        in_stall_phase = (phase_q == PH_A) || (phase_q == PH_B);
        stall          = in_stall_phase && mem_busy && (phase_q != PH_LAST);
        // A stop/halt request arriving on the final phase still ends this
        // instruction's pass rather than leaking into the next one.
        stop_now       = (mode_q == MODE_STEP) || stop_pend_q || exec || halt_req;
    end

    // Next-state logic for mode, phase, stop/halt flags and instruction counter.
    always_comb begin
        mode_d      = mode_q;
        phase_d     = phase_q;
        stop_pend_d = stop_pend_q;
        halted_d    = halted_q;
        cnt_d       = cnt_q;

        if (mode_q == MODE_IDLE) begin
            if (exec) begin
                mode_d      = MODE_RUN;
                phase_d     = PH_FIRST;
                halted_d    = 1'b0;
                stop_pend_d = 1'b0;
            end else if (step) begin
                mode_d      = MODE_STEP;
                phase_d     = PH_FIRST;
                halted_d    = 1'b0;
                stop_pend_d = 1'b0;
            end
        end else begin
            // step is deliberately ignored while an instruction is in flight.
            if (exec || halt_req) begin
                stop_pend_d = 1'b1;
            end
            if (halt_req) begin
                halted_d = 1'b1;
            end

            if (phase_q == PH_LAST) begin
                cnt_d       = cnt_q + CNT_W'(1);
                stop_pend_d = 1'b0;
                if (stop_now) begin
                    mode_d  = MODE_IDLE;
                    phase_d = PH_IDLE;
                end else begin
                    phase_d = PH_FIRST;
                end
            end else if (!stall) begin
                phase_d = phase_q + 3'd1;
            end
        end
    end

    // State and registered outputs; executing and pc_e are derived from the
    // next phase so they line up with phase without any decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_IDLE;
            phase_q     <= PH_IDLE;
            stop_pend_q <= 1'b0;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
            exec_q      <= 1'b0;
            pc_e_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            stop_pend_q <= stop_pend_d;
            halted_q    <= halted_d;
            cnt_q       <= cnt_d;
            exec_q      <= (phase_d != PH_IDLE);
            pc_e_q      <= (phase_d == PH_LAST);
        end
    end

    // IR loads on the fetch phase once memory has delivered the word.
    always_comb begin
        ir_e = (phase_q == PH_FIRST) && !mem_busy;
    end

    assign phase       = phase_q;
    assign executing   = exec_q;
    assign pc_e        = pc_e_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule
